muldiv_unit: RTL and testbench

Iterative multi-cycle multiply/divide/modulo engine in the execute stage, directly upstream of the memory-access stage. Computes SimpleRISC mul, div and mod on 32-bit signed operands. Drives its result onto the aluResult path that the memory-access stage consumes. Raises stall so the processor freezes PC and pipeline state until the result is ready.

---
 rtl/muldiv_unit.sv | 135 +++++++++++++
 tb/tb_muldiv_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed mul/div/mod engine; MULDIV_FAST_MUL_EN enables single-cycle multiply
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             isMul,
  input  logic             isDiv,
  input  logic             isMod,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_MOD} op_t;

  state_t             state, state_nxt;
  op_t                op_q, op_in;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               neg1, neg2;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   dq;
  logic [WIDTH-1:0]   result_q;

  logic               any_sel, accept, fast_mul;
  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH:0]     rem_sh, diff;
  logic [WIDTH-1:0]   fix_val;

  assign any_sel = isMul | isDiv | isMod;
  assign accept  = start & any_sel & (state == IDLE);
  assign op1_abs = op1[WIDTH-1] ? -op1 : op1;
  assign op2_abs = op2[WIDTH-1] ? -op2 : op2;

`ifdef MULDIV_FAST_MUL_EN
  assign fast_mul = isMul;
`else
  assign fast_mul = 1'b0;
`endif

  always_comb begin
    op_in = OP_MOD;
    if (isMul)      op_in = OP_MUL;
    else if (isDiv) op_in = OP_DIV;
  end

  // Restoring step: bring in the next dividend bit, keep the subtraction if it did not go negative
  assign rem_sh = {rem[WIDTH-1:0], dq[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, b_mag};

  // The overflow case (min / -1) falls out naturally: both signs negative, magnitude 2^(WIDTH-1)
  always_comb begin
    fix_val = '0;
    case (op_q)
      OP_MUL:  fix_val = (neg1 ^ neg2) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      OP_DIV:  fix_val = (b_mag == '0) ? '1 : ((neg1 ^ neg2) ? -dq : dq);
      default: fix_val = neg1 ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = fast_mul ? FIX : CALC;
      CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= OP_MUL;
      a_mag    <= '0;
      b_mag    <= '0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
      dq       <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= op_in;
            a_mag <= op1_abs;
            b_mag <= op2_abs;
            neg1  <= op1[WIDTH-1];
            neg2  <= op2[WIDTH-1];
            cnt   <= '0;
            rem   <= '0;
            dq    <= op1_abs;
            acc   <= '0;
`ifdef MULDIV_FAST_MUL_EN
            if (isMul) acc <= {{WIDTH{1'b0}}, op1_abs} * {{WIDTH{1'b0}}, op2_abs};
`endif
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q == OP_MUL) begin
            if (b_mag[cnt]) acc <= acc + ({{WIDTH{1'b0}}, a_mag} << cnt);
          end else if (!diff[WIDTH]) begin
            rem <= diff;
            dq  <= {dq[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            dq  <= {dq[WIDTH-2:0], 1'b0};
          end
        end
        FIX:     result_q <= fix_val;
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign busy   = (state == CALC) || (state == FIX);
  assign done   = (state == DONE);
  assign stall  = busy | accept;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit: vector table, random ops, corner sequences
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, isMul, isDiv, isMod;
  logic [31:0] op1, op2;
  logic [31:0] result;
  logic        busy, done, stall;

  int total = 0;
  int bad   = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start),
    .isMul(isMul), .isDiv(isDiv), .isMod(isMod),
    .op1(op1), .op2(op2),
    .result(result), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // op: 0 mul, 1 div, 2 mod
  function automatic logic [31:0] ref_model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r;
    if (op == 0) r = sa * sb;
    else if (b == 32'd0) r = (op == 1) ? -1 : sa;
    else if (op == 1) r = sa / sb;
    else r = sa % sb;
    return r[31:0];
  endfunction

  function automatic int exp_lat(input int op);
    return (FAST && op == 0) ? 2 : 34;
  endfunction

  // Called at posedge+1 with the unit idle; lat counts edges including the acceptance edge
  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b,
                       input int inject_at, output logic [31:0] res, output int lat);
    start = 1'b1; isMul = (op == 0); isDiv = (op == 1); isMod = (op == 2);
    op1 = a; op2 = b;
    #1 check("stall_accept", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    lat = 1;
    start = 1'b0; isMul = 1'b0; isDiv = 1'b0; isMod = 1'b0;
    op1 = $urandom; op2 = $urandom;
    while (!done && lat < 200) begin
      if (lat == inject_at) begin
        start = 1'b1; isDiv = 1'b1; op1 = 32'd12345; op2 = 32'd7;
      end else begin
        start = 1'b0; isDiv = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0; isDiv = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    res = result;
    check("stall_in_done", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("result_hold", result, res);
  endtask

  vec_t        vecs[$];
  logic [31:0] res, a, b;
  int          lat, op, pulses;

  initial begin
    reset = 1'b1; start = 1'b0; isMul = 1'b0; isDiv = 1'b0; isMod = 1'b0;
    op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_result", result, 32'd0);
    check("reset_busy",  {31'd0, busy},  32'd0);
    check("reset_done",  {31'd0, done},  32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);

    // start with no select is ignored
    start = 1'b1; op1 = 32'd9; op2 = 32'd9;
    #1 check("nosel_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1 start = 1'b0;
    check("nosel_busy", {31'd0, busy}, 32'd0);

    vecs.push_back('{0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1});
    vecs.push_back('{1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD});
    vecs.push_back('{2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF});
    vecs.push_back('{2, 32'd7,        32'hFFFFFFFE, 32'd1});
    vecs.push_back('{1, 32'd100,      32'd0,        32'hFFFFFFFF});
    vecs.push_back('{2, 32'd100,      32'd0,        32'd100});
    vecs.push_back('{1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    vecs.push_back('{2, 32'h80000000, 32'hFFFFFFFF, 32'd0});
    vecs.push_back('{0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    vecs.push_back('{0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1});
    vecs.push_back('{1, 32'd0,        32'd5,        32'd0});
    vecs.push_back('{1, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'd2});
    vecs.push_back('{2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE});
    vecs.push_back('{2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9});

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].op));
    end

    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 2);
      a = $urandom;
      b = (i % 5 == 0) ? $urandom_range(0, 3) - 1 : $urandom;
      if (i % 7 == 0) a = a >> $urandom_range(0, 31);
      do_op(op, a, b, -1, res, lat);
      check($sformatf("rand%0d_op%0d_result", i, op), res, ref_model(op, a, b));
      check($sformatf("rand%0d_latency", i), lat, exp_lat(op));
    end

    // start pulse during CALC must be ignored
    do_op(1, 32'h80000000, 32'hFFFFFFFF, 5, res, lat);
    check("inject_result", res, 32'h80000000);
    check("inject_latency", lat, 34);
    do_op(0, 32'd6, 32'hFFFFFFF9, 1, res, lat);
    check("inject_mul_result", res, 32'hFFFFFFD6);
    check("inject_mul_latency", lat, exp_lat(0));

    // reset mid-operation on a divide: result must clear and no done may follow
    start = 1'b1; isDiv = 1'b1; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; isDiv = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("midreset_result", result, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_stall", {31'd0, stall}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("midreset_no_done", pulses, 0);
    do_op(1, 32'd1000, 32'd3, -1, res, lat);
    check("after_reset_result", res, 32'd333);
    check("after_reset_latency", lat, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
